// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the RV32I multicycle controller:
//   - state_e   : FSM state encoding (16 states, 4 bits)
//   - OP_*      : RV32I major opcodes recognised by the controller
//   - RES_*, SRCA_*, SRCB_*, ALUOP_*, IMM_* : select encodings for the datapath
//   - ctrl_t    : Moore control word held in a register beside the state
//   - state_ctrl: Moore control word for a given state
//   - is_known_op: true for every opcode that has an execution sequence
// -----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR_TGT,
        S_JALR_LINK,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // pc_update and ir_write are qualified by mem_ready in FETCH; branch is
    // qualified by branch_taken. done covers retirement that depends on state only.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
                c.ir_write   = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_BRANCH;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.done       = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_JALR_TGT: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            S_JALR_LINK: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
            end
            S_TRAP: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic is_known_op(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_B, OP_I, OP_JAL, OP_JALR,
                          OP_LUI, OP_AUIPC, OP_NOP};
    endfunction

endpackage

// File: rtl/mc_if.sv
// -----------------------------------------------------------------------------
// mc_if
// Control bus between the multicycle controller and the datapath.
//   Datapath -> controller : op, branch_taken, mem_ready
//   Controller -> datapath : PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
//                            ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
//                            instr_done, illegal
// modport master : the controller side
// modport slave  : the datapath side
// -----------------------------------------------------------------------------
interface mc_if;
    logic [6:0] op;
    logic       branch_taken;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmSrc;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, branch_taken, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );

    modport slave (
        output op, branch_taken, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
    );
endinterface

// File: rtl/mc_immsrc_dec.sv
// -----------------------------------------------------------------------------
// mc_immsrc_dec
// Combinational opcode -> immediate-format decode, independent of FSM state.
//   op_i      in  7  opcode field of the instruction register
//   imm_src_o out 3  immediate format (I/S/B/J/U)
// -----------------------------------------------------------------------------
module mc_immsrc_dec
    import mc_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [2:0] imm_src_o
);

    // NOTE: assign a default before the case so every path drives the output;
    // otherwise synthesis infers a latch for the unlisted opcodes.
    always_comb begin
        imm_src_o = IMM_I;
        case (op_i)
            OP_SW:            imm_src_o = IMM_S;
            OP_B:             imm_src_o = IMM_B;
            OP_JAL:           imm_src_o = IMM_J;
            OP_LUI, OP_AUIPC: imm_src_o = IMM_U;
            default:          imm_src_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multicycle control FSM for the RV32I core with a memory-ready handshake and
// an illegal-opcode trap.
//   clk      in   core clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   bus      mc_if.master: opcode/handshake in, datapath controls out
//   state_o  out  current state, for debug
// Parameters:
//   TRAP_ON_ILLEGAL  1: unknown opcode enters TRAP; 0: retired as a NOP
//   STATE_W          width of state_o
// -----------------------------------------------------------------------------
module mc_controller
    import mc_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int STATE_W         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_if.master               bus,
    output logic [STATE_W-1:0] state_o
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   in_fetch;
    logic   decode_retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR_TGT;
                    OP_LUI:       state_d = S_LUI;
                    OP_AUIPC:     state_d = S_ALUWB;
                    OP_NOP:       state_d = S_FETCH;
                    default:      state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:    state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_LUI:       state_d = S_ALUWB;
            S_ALUWB,
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALUWB;
            S_JALR_TGT:  state_d = S_JALR_LINK;
            S_JALR_LINK: state_d = S_ALUWB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_RST;
        endcase
    end

    // The Moore control word is computed from the next state so it lands in
    // its register together with the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    assign in_fetch = (state_q == S_FETCH);

    // NOP, and unknown opcodes when not trapping, retire straight out of DECODE.
    assign decode_retire = (state_q == S_DECODE) &&
                           ((bus.op == OP_NOP) ||
                            (!TRAP_ON_ILLEGAL && !is_known_op(bus.op)));

    // The fetch-phase PC update waits for the instruction word to arrive.
    assign bus.PCWrite    = (ctrl_q.pc_update & (~in_fetch | bus.mem_ready)) |
                            (ctrl_q.branch & bus.branch_taken);
    assign bus.IRWrite    = ctrl_q.ir_write & bus.mem_ready;
    assign bus.AdrSrc     = ctrl_q.adr_src;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.ResultSrc  = ctrl_q.result_src;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.ALUOp      = ctrl_q.alu_op;
    assign bus.illegal    = ctrl_q.illegal;
    // A store retires in the cycle memory accepts it.
    assign bus.instr_done = ctrl_q.done | decode_retire |
                            (ctrl_q.mem_write & bus.mem_ready);

    assign state_o = STATE_W'(state_q);

    mc_immsrc_dec u_immsrc (
        .op_i      (bus.op),
        .imm_src_o (bus.ImmSrc)
    );

endmodule
